// File: rtl/cpu_run_ctrl_pkg.sv
// Shared types and defaults for the core run controller.
// State and halt-cause encodings are visible on the debug outputs.
package run_ctrl_pkg;

  localparam int DEFAULT_RST_HOLD_CYCLES = 50;

  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RUN    = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE  = 2'd0,
    CAUSE_LIMIT = 2'd1,
    CAUSE_EXT   = 2'd2
  } cause_t;

endpackage

// File: rtl/cpu_run_ctrl_if.sv
// Control/status bundle between a run supervisor (master) and the run controller (slave).
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 32
);

  logic             start;
  logic             step_mode;
  logic             step_req;
  logic             halt_req;
  logic             soft_rst;
  logic [CNT_W-1:0] run_limit;
  logic             core_rst_n;
  logic             core_clk_en;
  logic [CNT_W-1:0] cycle_count;
  logic             done;
  logic [1:0]       halt_cause;
  logic [2:0]       state_o;

  modport master (
    output start, step_mode, step_req, halt_req, soft_rst, run_limit,
    input  core_rst_n, core_clk_en, cycle_count, done, halt_cause, state_o
  );

  modport slave (
    input  start, step_mode, step_req, halt_req, soft_rst, run_limit,
    output core_rst_n, core_clk_en, cycle_count, done, halt_cause, state_o
  );

endinterface

// File: rtl/cpu_run_ctrl_rise_detect.sv
// One-bit registered rising-edge detector; o_rise is high in the cycle i_d first goes high.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_prev <= 1'b0;
    else        r_prev <= i_d;
  end

  assign o_rise = i_d & ~r_prev;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Core run controller: reset hold sequencing, free/limited/single-step runs,
// halt reporting and saturating executed-cycle count.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYCLES = DEFAULT_RST_HOLD_CYCLES,
  parameter int CNT_W           = 32,
  parameter int HOLD_W          = $clog2(RST_HOLD_CYCLES + 1)
) (
  input logic           clk,
  input logic           rst_n,
  cpu_run_ctrl_if.slave io_ctrl
);

  state_t            r_state;
  cause_t            r_cause;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              r_core_rst_n;
  logic              r_core_clk_en;
  logic [CNT_W-1:0]  r_cycle_count;

  state_t            w_nxt_state;
  cause_t            w_nxt_cause;
  logic [HOLD_W-1:0] w_nxt_hold_cnt;
  logic              w_nxt_core_rst_n;
  logic              w_nxt_core_clk_en;
  logic              w_step_rise;
  logic              w_counted;
  logic              w_last;
  logic              w_enter_hold;

  rise_detect u_step_rise (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_d    (io_ctrl.step_req),
    .o_rise (w_step_rise)
  );

  // The core executes a cycle on any edge where it is enabled and out of reset.
  assign w_counted = r_core_clk_en & r_core_rst_n;
  assign w_last    = w_counted && (io_ctrl.run_limit != '0) &&
                     (({1'b0, r_cycle_count} + (CNT_W+1)'(1)) == {1'b0, io_ctrl.run_limit});
  assign w_enter_hold = io_ctrl.soft_rst | ((r_state == ST_HALTED) & io_ctrl.start);

  always_comb begin
    w_nxt_state       = r_state;
    w_nxt_cause       = r_cause;
    w_nxt_hold_cnt    = r_hold_cnt;
    w_nxt_core_rst_n  = r_core_rst_n;
    w_nxt_core_clk_en = r_core_clk_en;
    if (w_enter_hold) begin
      w_nxt_state       = ST_HOLD;
      w_nxt_cause       = CAUSE_NONE;
      w_nxt_hold_cnt    = '0;
      w_nxt_core_rst_n  = 1'b0;
      w_nxt_core_clk_en = 1'b1;
    end else begin
      case (r_state)
        ST_HOLD: begin
          if (r_hold_cnt == HOLD_W'(RST_HOLD_CYCLES - 1)) begin
            w_nxt_state       = ST_IDLE;
            w_nxt_hold_cnt    = '0;
            w_nxt_core_rst_n  = 1'b1;
            w_nxt_core_clk_en = 1'b0;
          end else begin
            w_nxt_hold_cnt = r_hold_cnt + HOLD_W'(1);
          end
        end
        ST_IDLE: begin
          w_nxt_core_clk_en = 1'b0;
          if (io_ctrl.start) begin
            w_nxt_state       = io_ctrl.step_mode ? ST_STEP : ST_RUN;
            w_nxt_core_clk_en = ~io_ctrl.step_mode;
          end
        end
        ST_RUN: begin
          w_nxt_core_clk_en = 1'b1;
          if (io_ctrl.halt_req) begin
            w_nxt_state       = ST_HALTED;
            w_nxt_cause       = CAUSE_EXT;
            w_nxt_core_clk_en = 1'b0;
          end else if (w_last) begin
            w_nxt_state       = ST_HALTED;
            w_nxt_cause       = CAUSE_LIMIT;
            w_nxt_core_clk_en = 1'b0;
          end
        end
        ST_STEP: begin
          w_nxt_core_clk_en = w_step_rise;
          if (io_ctrl.halt_req) begin
            w_nxt_state       = ST_HALTED;
            w_nxt_cause       = CAUSE_EXT;
            w_nxt_core_clk_en = 1'b0;
          end else if (w_last) begin
            w_nxt_state       = ST_HALTED;
            w_nxt_cause       = CAUSE_LIMIT;
            w_nxt_core_clk_en = 1'b0;
          end
        end
        ST_HALTED: begin
          w_nxt_core_clk_en = 1'b0;
        end
        default: begin
          w_nxt_state       = ST_HOLD;
          w_nxt_hold_cnt    = '0;
          w_nxt_core_rst_n  = 1'b0;
          w_nxt_core_clk_en = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_HOLD;
      r_cause       <= CAUSE_NONE;
      r_hold_cnt    <= '0;
      r_core_rst_n  <= 1'b0;
      r_core_clk_en <= 1'b1;
    end else begin
      r_state       <= w_nxt_state;
      r_cause       <= w_nxt_cause;
      r_hold_cnt    <= w_nxt_hold_cnt;
      r_core_rst_n  <= w_nxt_core_rst_n;
      r_core_clk_en <= w_nxt_core_clk_en;
    end
  end

  // Re-entering HOLD clears the count even if the core also ran on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_count <= '0;
    end else if (w_enter_hold) begin
      r_cycle_count <= '0;
    end else if (w_counted && (r_cycle_count != {CNT_W{1'b1}})) begin
      r_cycle_count <= r_cycle_count + CNT_W'(1);
    end
  end

  assign io_ctrl.core_rst_n  = r_core_rst_n;
  assign io_ctrl.core_clk_en = r_core_clk_en;
  assign io_ctrl.cycle_count = r_cycle_count;
  assign io_ctrl.done        = (r_state == ST_HALTED);
  assign io_ctrl.halt_cause  = r_cause;
  assign io_ctrl.state_o     = r_state;

endmodule
